dbg_sba: RTL and testbench

DBG_SBA -- requirements
Module: dbg_sba

---
 rtl/dbg_sba.sv | 197 +++++++++++++++++++
 tb/tb_dbg_sba.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_sba.sv
// Debug system-bus access engine: turns debugger commands into single-beat
// bus transactions, with size/alignment checks, bursts and a response timeout.
module dbg_sba #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_wdata_i,
   input  logic [1:0]        cmd_size_i,
   input  logic              cmd_autoinc_i,
   input  logic [CNT_W-1:0]  cmd_count_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              rsp_last_o,
   output logic              req_valid_o,
   input  logic              req_ready_i,
   output logic              mem_we_o,
   output logic [DATA_W/8-1:0] mem_sel_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              bus_rsp_valid_i,
   output logic              bus_rsp_ready_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              bus_err_i,
   output logic              busy_o
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam logic [31:0] TLIM = 32'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic              autoinc_q, autoinc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [31:0]       tcnt_q, tcnt_d;
   logic              stale_q, stale_d;
   logic              init_q;

   logic [2:0]        cmd_amask;
   logic              cmd_bad;
   logic [OFF_W-1:0]  off;
   logic [3:0]        nbytes;
   logic [NB-1:0]     lmask;
   logic [DATA_W-1:0] wrep;
   logic [DATA_W-1:0] rmask;
   logic [DATA_W-1:0] rshift;
   logic              in_req;

   assign cmd_amask = 3'((4'd1 << cmd_size_i) - 4'd1);
   assign cmd_bad   = ((cmd_addr_i[2:0] & cmd_amask) != 3'd0)
                   || ((5'd1 << cmd_size_i) > 5'(NB));

   assign off    = addr_q[OFF_W-1:0];
   assign nbytes = 4'd1 << size_q;
   assign lmask  = NB'((17'd1 << nbytes) - 17'd1);
   assign rshift = mem_rdata_i >> {off, 3'b000};
   assign in_req = (state_q == REQ);

   // Lane replication of write data and size mask for read data.
   always_comb begin
      wrep  = '0;
      rmask = '0;
      for (int i = 0; i < NB; i++) begin
         wrep[8*i +: 8]  = wdata_q[8*(i & (int'(nbytes) - 1)) +: 8];
         rmask[8*i +: 8] = (i < int'(nbytes)) ? 8'hFF : 8'h00;
      end
   end

   // Ready only after one reset-free edge, so it stays low while rst is held.
   assign cmd_ready_o     = init_q && (state_q == IDLE);
   assign busy_o          = (state_q != IDLE);
   // A timed-out response still owed by the bus blocks the next request.
   assign req_valid_o     = in_req && !stale_q;
   assign mem_we_o        = in_req && write_q;
   assign mem_sel_o       = in_req ? (lmask << off) : '0;
   assign mem_addr_o      = in_req ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign mem_wdata_o     = in_req ? wrep : '0;
   assign bus_rsp_ready_o = (state_q == WAIT) || stale_q;
   assign rsp_valid_o     = (state_q == RESP);
   assign rsp_rdata_o     = rsp_valid_o ? rdata_q : '0;
   assign rsp_err_o       = rsp_valid_o && err_q;
   assign rsp_last_o      = rsp_valid_o && (err_q || cnt_q == CNT_W'(1));

   // Next-state and latched-field update.
   always_comb begin
      state_d   = state_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      size_d    = size_q;
      autoinc_d = autoinc_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      tcnt_d    = tcnt_q;
      stale_d   = stale_q;
      if (stale_q && bus_rsp_valid_i) stale_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i && cmd_ready_o) begin
               write_d   = cmd_write_i;
               addr_d    = cmd_addr_i;
               wdata_d   = cmd_wdata_i;
               size_d    = cmd_size_i;
               autoinc_d = cmd_autoinc_i;
               cnt_d     = (cmd_write_i || cmd_count_i == '0)
                         ? CNT_W'(1) : cmd_count_i;
               err_d     = cmd_bad;
               rdata_d   = '0;
               tcnt_d    = '0;
               state_d   = cmd_bad ? RESP : REQ;
            end
         end
         REQ: begin
            if (req_valid_o && req_ready_i) begin
               tcnt_d  = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (bus_rsp_valid_i) begin
               err_d   = bus_err_i;
               rdata_d = (write_q || bus_err_i) ? '0 : (rshift & rmask);
               state_d = RESP;
            end else if (TIMEOUT != 0 && tcnt_q == TLIM) begin
               err_d   = 1'b1;
               rdata_d = '0;
               stale_d = 1'b1;
               state_d = RESP;
            end else begin
               tcnt_d = tcnt_q + 32'd1;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               if (err_q || cnt_q == CNT_W'(1)) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
                  if (autoinc_q) addr_d = addr_q + (ADDR_W'(1) << size_q);
                  state_d = REQ;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latched-field registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         size_q    <= '0;
         autoinc_q <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         tcnt_q    <= '0;
         stale_q   <= 1'b0;
         init_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         size_q    <= size_d;
         autoinc_q <= autoinc_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         tcnt_q    <= tcnt_d;
         stale_q   <= stale_d;
         init_q    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dbg_sba.sv
// Bench for dbg_sba: scoreboarded bus requests and responses, bursts,
// alignment errors, bus errors, timeout with late response, reset in WAIT.
module tb_dbg_sba;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_write_i;
   logic [31:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic [1:0]  cmd_size_i;
   logic        cmd_autoinc_i;
   logic [7:0]  cmd_count_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_last_o;
   logic        req_valid_o;
   logic        req_ready_i;
   logic        mem_we_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        bus_rsp_valid_i;
   logic        bus_rsp_ready_o;
   logic [31:0] mem_rdata_i;
   logic        bus_err_i;
   logic        busy_o;

   typedef struct {
      logic        we;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          dly;
      logic        silent;
   } bus_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        last;
   } rsp_t;

   bus_t bq[$];
   rsp_t rq[$];
   logic bus_busy;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   dbg_sba #(.ADDR_W(32), .DATA_W(32), .CNT_W(8), .TIMEOUT(4)) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid_i(cmd_valid_i),
      .cmd_ready_o(cmd_ready_o),
      .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i),
      .cmd_wdata_i(cmd_wdata_i),
      .cmd_size_i(cmd_size_i),
      .cmd_autoinc_i(cmd_autoinc_i),
      .cmd_count_i(cmd_count_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o),
      .rsp_last_o(rsp_last_o),
      .req_valid_o(req_valid_o),
      .req_ready_i(req_ready_i),
      .mem_we_o(mem_we_o),
      .mem_sel_o(mem_sel_o),
      .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .bus_rsp_valid_i(bus_rsp_valid_i),
      .bus_rsp_ready_o(bus_rsp_ready_o),
      .mem_rdata_i(mem_rdata_i),
      .bus_err_i(bus_err_i),
      .busy_o(busy_o)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [3:0] lanes(input logic [1:0] size,
                                        input logic [1:0] off);
      case (size)
         2'd0:    return 4'(4'b0001 << off);
         2'd1:    return 4'(4'b0011 << off);
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] rep(input logic [31:0] w,
                                       input logic [1:0] size);
      case (size)
         2'd0:    return {4{w[7:0]}};
         2'd1:    return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] extr(input logic [31:0] w,
                                        input logic [1:0] off,
                                        input logic [1:0] size);
      logic [31:0] s;
      s = w >> (8 * off);
      case (size)
         2'd0:    return {24'h0, s[7:0]};
         2'd1:    return {16'h0, s[15:0]};
         default: return s;
      endcase
   endfunction

   // Bus slave: checks each request against the scoreboard, then answers.
   initial begin
      bus_t b;
      int   n;
      req_ready_i     = 1'b0;
      bus_rsp_valid_i = 1'b0;
      mem_rdata_i     = '0;
      bus_err_i       = 1'b0;
      bus_busy        = 1'b0;
      forever begin
         @(negedge clk);
         if (req_valid_o && !rst) begin
            check("req_expected", 64'(bq.size() != 0), 64'd1);
            if (bq.size() != 0) begin
               b = bq.pop_front();
               check("mem_we", 64'(mem_we_o), 64'(b.we));
               check("mem_sel", 64'(mem_sel_o), 64'(b.sel));
               check("mem_addr", 64'(mem_addr_o), 64'(b.addr));
               if (b.we) check("mem_wdata", 64'(mem_wdata_o), 64'(b.wdata));
            end else begin
               b.silent = 1'b1;
               b.dly    = 0;
            end
            bus_busy    = 1'b1;
            req_ready_i = 1'b1;
            @(negedge clk);
            req_ready_i = 1'b0;
            if (!b.silent) begin
               repeat (b.dly) @(negedge clk);
               bus_rsp_valid_i = 1'b1;
               mem_rdata_i     = b.rdata;
               bus_err_i       = b.err;
               n = 0;
               while (!bus_rsp_ready_o && n < 50) begin
                  @(negedge clk);
                  n++;
               end
               check("bus_rsp_accepted", 64'(n < 50), 64'd1);
               @(negedge clk);
               bus_rsp_valid_i = 1'b0;
               bus_err_i       = 1'b0;
               mem_rdata_i     = '0;
            end
            bus_busy = 1'b0;
         end
      end
   end

   // Response sink with random backpressure; compares against the scoreboard.
   initial begin
      rsp_t r;
      rsp_ready_i = 1'b0;
      forever begin
         @(negedge clk);
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         if (rsp_valid_o && rsp_ready_i) begin
            check("rsp_expected", 64'(rq.size() != 0), 64'd1);
            if (rq.size() != 0) begin
               r = rq.pop_front();
               check("rsp_rdata", 64'(rsp_rdata_o), 64'(r.rdata));
               check("rsp_err", 64'(rsp_err_o), 64'(r.err));
               check("rsp_last", 64'(rsp_last_o), 64'(r.last));
            end
         end
      end
   end

   task automatic send(input logic wr, input logic [31:0] addr,
                       input logic [1:0] size, input logic inc,
                       input logic [7:0] cnt, input logic [31:0] wd,
                       input logic exp_req);
      int n;
      @(negedge clk);
      cmd_write_i   = wr;
      cmd_addr_i    = addr;
      cmd_size_i    = size;
      cmd_autoinc_i = inc;
      cmd_count_i   = cnt;
      cmd_wdata_i   = wd;
      cmd_valid_i   = 1'b1;
      n = 0;
      while (!cmd_ready_o && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accepted", 64'(n < 500), 64'd1);
      @(negedge clk);
      cmd_valid_i = 1'b0;
      check("req_after_cmd", 64'(req_valid_o), 64'(exp_req));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy_o || bus_busy || rq.size() != 0 || bq.size() != 0)
             && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", 64'(n < 400), 64'd1);
   endtask

   task automatic do_cmd(input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic inc,
                         input logic [7:0] cnt, input logic [31:0] wd,
                         input logic [31:0] rd0, input int errbeat);
      int          beats;
      logic        bad;
      logic [31:0] a;
      logic [31:0] w;
      bus_t        b;
      rsp_t        r;
      beats = (wr || cnt == 8'd0) ? 1 : int'(cnt);
      bad   = (size == 2'd3) || ((addr & ((32'd1 << size) - 32'd1)) != 0);
      if (bad) begin
         r.rdata = '0;
         r.err   = 1'b1;
         r.last  = 1'b1;
         rq.push_back(r);
      end else begin
         for (int k = 0; k < beats; k++) begin
            a        = addr + (inc ? (32'(k) << size) : 32'd0);
            w        = rd0 + 32'(k) * 32'h01020304;
            b.we     = wr;
            b.sel    = lanes(size, a[1:0]);
            b.addr   = {a[31:2], 2'b00};
            b.wdata  = rep(wd, size);
            b.rdata  = w;
            b.err    = (k + 1 == errbeat);
            b.dly    = $urandom_range(0, 2);
            b.silent = 1'b0;
            bq.push_back(b);
            r.rdata  = (wr || b.err) ? 32'd0 : extr(w, a[1:0], size);
            r.err    = b.err;
            r.last   = b.err || (k == beats - 1);
            rq.push_back(r);
            if (b.err) break;
         end
      end
      send(wr, addr, size, inc, cnt, wd, !bad);
      wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus_t        b;
      rsp_t        r;
      int          n;
      int          w;
      logic [1:0]  sz;
      logic [31:0] ad;
      rst           = 1'b1;
      cmd_valid_i   = 1'b0;
      cmd_write_i   = 1'b0;
      cmd_addr_i    = '0;
      cmd_wdata_i   = '0;
      cmd_size_i    = '0;
      cmd_autoinc_i = 1'b0;
      cmd_count_i   = '0;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_req_valid", 64'(req_valid_o), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_bus_rsp_ready", 64'(bus_rsp_ready_o), 64'd0);
      check("rst_mem_sel", 64'(mem_sel_o), 64'd0);
      check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
      check("rst_rsp_last", 64'(rsp_last_o), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);

      do_cmd(1'b0, 32'h100, 2'd2, 1'b0, 8'd1, 32'h0, 32'hDEADBEEF, 0);
      do_cmd(1'b1, 32'h103, 2'd0, 1'b0, 8'd1, 32'h5A, 32'h0, 0);
      do_cmd(1'b0, 32'h200, 2'd2, 1'b1, 8'd3, 32'h0, 32'h11223344, 0);
      do_cmd(1'b0, 32'h101, 2'd1, 1'b0, 8'd1, 32'h0, 32'h0, 0);
      do_cmd(1'b0, 32'h300, 2'd2, 1'b1, 8'd4, 32'h0, 32'hCAFEF00D, 2);
      check("busy_after_bus_err", 64'(busy_o), 64'd0);
      do_cmd(1'b0, 32'h400, 2'd3, 1'b0, 8'd1, 32'h0, 32'h0, 0);
      do_cmd(1'b0, 32'hFFFF_FFFC, 2'd2, 1'b1, 8'd2, 32'h0, 32'hA5A5_0001, 0);
      do_cmd(1'b0, 32'h502, 2'd1, 1'b0, 8'd0, 32'h0, 32'h8765_4321, 0);
      do_cmd(1'b1, 32'h602, 2'd1, 1'b0, 8'd5, 32'hBEEF, 32'h0, 0);
      do_cmd(1'b0, 32'h701, 2'd0, 1'b1, 8'd3, 32'h0, 32'h7766_5544, 0);

      for (int t = 0; t < 16; t++) begin
         sz = 2'($urandom_range(0, 2));
         ad = $urandom() & ~((32'd1 << sz) - 32'd1);
         do_cmd(1'($urandom_range(0, 1)), ad, sz, 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 3)), $urandom(), $urandom(), 0);
      end

      b.we = 1'b0;  b.sel = 4'hF;  b.addr = 32'h800;  b.wdata = '0;
      b.rdata = 32'h1234_5678;  b.err = 1'b0;  b.dly = 10;  b.silent = 1'b0;
      bq.push_back(b);
      r.rdata = '0;  r.err = 1'b1;  r.last = 1'b1;
      rq.push_back(r);
      send(1'b0, 32'h800, 2'd2, 1'b0, 8'd1, 32'h0, 1'b1);
      n = 0;
      w = 0;
      while (!rsp_valid_o && n < 50) begin
         if (bus_rsp_ready_o && busy_o) w++;
         @(negedge clk);
         n++;
      end
      check("timeout_wait_cycles", 64'(w), 64'd4);
      wait_idle();
      do_cmd(1'b0, 32'h804, 2'd2, 1'b0, 8'd1, 32'h0, 32'h0BAD_F00D, 0);

      b.addr = 32'h900;  b.silent = 1'b1;  b.dly = 0;
      bq.push_back(b);
      send(1'b0, 32'h900, 2'd2, 1'b0, 8'd1, 32'h0, 1'b1);
      n = 0;
      while (!bus_rsp_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("reached_wait", 64'(bus_rsp_ready_o), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("wrst_busy", 64'(busy_o), 64'd0);
      check("wrst_cmd_ready", 64'(cmd_ready_o), 64'd0);
      check("wrst_bus_rsp_ready", 64'(bus_rsp_ready_o), 64'd0);
      check("wrst_req_valid", 64'(req_valid_o), 64'd0);
      check("wrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("wrst_mem_sel", 64'(mem_sel_o), 64'd0);
      check("wrst_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("wrst_ready_after", 64'(cmd_ready_o), 64'd1);
      wait_idle();
      do_cmd(1'b0, 32'hA02, 2'd1, 1'b0, 8'd1, 32'h0, 32'hF00D_CAFE, 0);

      check("scoreboard_empty", 64'(rq.size() + bq.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
